// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with load, terminal-count pulse, sticky overflow and optional snapshot register.
// Define UPDOWN_MOD_COUNTER_CAPTURE_EN to build the capture register; otherwise capture_val is tied to zero.
module updown_mod_counter #(
  parameter int unsigned     WIDTH    = 12,
  parameter longint unsigned MODULUS  = 4096,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  input  logic             capture,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic [WIDTH-1:0] capture_val
);

  // Comparisons against MODULUS use one extra bit so MODULUS = 2^WIDTH cannot overflow.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

  logic             at_limit;
  logic             terminal;
  logic [WIDTH-1:0] next_step;
  logic [WIDTH-1:0] load_clamped;

  always_comb begin
    at_limit     = up ? (count == MAX_VAL) : (count == '0);
    terminal     = en & ~load & at_limit;
    load_clamped = ({1'b0, load_val} >= MOD_EXT) ? MAX_VAL : load_val;
    next_step    = count;
    if (!at_limit) begin
      next_step = up ? (count + WIDTH'(1)) : (count - WIDTH'(1));
    end else if (!SATURATE) begin
      next_step = up ? '0 : MAX_VAL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      tc <= terminal;
      if (load) begin
        count <= load_clamped;
      end else if (en) begin
        count <= next_step;
      end
      // A terminal event wins over a simultaneous clear.
      if (terminal) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

`ifdef UPDOWN_MOD_COUNTER_CAPTURE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      capture_val <= '0;
    end else if (capture) begin
      capture_val <= count;
    end
  end
`else
  logic unused_capture;
  assign unused_capture = capture;
  assign capture_val    = '0;
`endif

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter across four parameterisations sharing one input bus.
// Capture expectations follow whether UPDOWN_MOD_COUNTER_CAPTURE_EN is defined for this build.
module tb_updown_mod_counter;

  logic        clk;
  logic        reset;
  logic        en;
  logic        up;
  logic        load;
  logic [11:0] load_val;
  logic        clr_ovf;
  logic        capture;

  logic [11:0] count_d, cap_d, count_m, cap_m, count_s, cap_s, count_k, cap_k;
  logic        tc_d, ovf_d, tc_m, ovf_m, tc_s, ovf_s, tc_k, ovf_k;

  int checks;
  int errors;

  // Defaults: WIDTH=12, MODULUS=4096, wrapping.
  updown_mod_counter dut_def (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .clr_ovf(clr_ovf), .capture(capture), .count(count_d), .tc(tc_d), .ovf(ovf_d),
    .capture_val(cap_d));

  updown_mod_counter #(.WIDTH(12), .MODULUS(10), .SATURATE(1'b0)) dut_mod10 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .clr_ovf(clr_ovf), .capture(capture), .count(count_m), .tc(tc_m), .ovf(ovf_m),
    .capture_val(cap_m));

  updown_mod_counter #(.WIDTH(12), .MODULUS(10), .SATURATE(1'b1)) dut_sat10 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .clr_ovf(clr_ovf), .capture(capture), .count(count_s), .tc(tc_s), .ovf(ovf_s),
    .capture_val(cap_s));

  updown_mod_counter #(.WIDTH(12), .MODULUS(1000), .SATURATE(1'b0)) dut_mod1000 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .clr_ovf(clr_ovf), .capture(capture), .count(count_k), .tc(tc_k), .ovf(ovf_k),
    .capture_val(cap_k));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; en = 0; up = 1; load = 0; load_val = '0; clr_ovf = 0; capture = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    load = 1; load_val = 12'd55; en = 1; clr_ovf = 1; capture = 1; reset = 1;
    step();
    checks++;
    if (count_d !== 12'd0 || tc_d !== 1'b0 || ovf_d !== 1'b0 || cap_d !== 12'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: got count=%0d tc=%b ovf=%b cap=%0d, want 0 0 0 0",
               count_d, tc_d, ovf_d, cap_d);
    end
    idle_inputs();
  endtask

  task automatic test_full_wrap();
    do_reset();
    en = 1; up = 1;
    for (int i = 1; i <= 4095; i++) begin
      step();
      checks++;
      if (count_d !== 12'(i) || tc_d !== 1'b0) begin
        errors++;
        $display("[TB] FAIL wrap_climb: step %0d got count=%0d tc=%b, want %0d 0",
                 i, count_d, tc_d, i);
        break;
      end
    end
    step();
    checks++;
    if (count_d !== 12'd0 || tc_d !== 1'b1 || ovf_d !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wrap_edge: got count=%0d tc=%b ovf=%b, want 0 1 1", count_d, tc_d, ovf_d);
    end
    step();
    checks++;
    if (count_d !== 12'd1 || tc_d !== 1'b0 || ovf_d !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wrap_after: got count=%0d tc=%b ovf=%b, want 1 0 1", count_d, tc_d, ovf_d);
    end
    up = 0;
    step();
    checks++;
    if (count_d !== 12'd0 || tc_d !== 1'b0) begin
      errors++;
      $display("[TB] FAIL dir_change: got count=%0d tc=%b, want 0 0", count_d, tc_d);
    end
    step();
    checks++;
    if (count_d !== 12'd4095 || tc_d !== 1'b1) begin
      errors++;
      $display("[TB] FAIL underflow_def: got count=%0d tc=%b, want 4095 1", count_d, tc_d);
    end
    idle_inputs();
  endtask

  task automatic test_down_wrap();
    do_reset();
    en = 1; up = 0;
    step();
    checks++;
    if (count_m !== 12'd9 || tc_m !== 1'b1 || ovf_m !== 1'b1) begin
      errors++;
      $display("[TB] FAIL down_wrap: got count=%0d tc=%b ovf=%b, want 9 1 1", count_m, tc_m, ovf_m);
    end
    step();
    checks++;
    if (count_m !== 12'd8 || tc_m !== 1'b0 || ovf_m !== 1'b1) begin
      errors++;
      $display("[TB] FAIL down_after: got count=%0d tc=%b ovf=%b, want 8 0 1", count_m, tc_m, ovf_m);
    end
    en = 0; clr_ovf = 1;
    step();
    checks++;
    if (count_m !== 12'd8 || ovf_m !== 1'b0 || tc_m !== 1'b0) begin
      errors++;
      $display("[TB] FAIL down_clear: got count=%0d tc=%b ovf=%b, want 8 0 0", count_m, tc_m, ovf_m);
    end
    idle_inputs();
  endtask

  task automatic test_saturate();
    logic [11:0] exp_cnt [4];
    logic        exp_tc  [4];
    exp_cnt = '{12'd9, 12'd9, 12'd9, 12'd9};
    exp_tc  = '{1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    load = 1; load_val = 12'd8;
    step();
    checks++;
    if (count_s !== 12'd8 || tc_s !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sat_load: got count=%0d tc=%b, want 8 0", count_s, tc_s);
    end
    load = 0; en = 1; up = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (count_s !== exp_cnt[i] || tc_s !== exp_tc[i]) begin
        errors++;
        $display("[TB] FAIL sat_up: update %0d got count=%0d tc=%b, want %0d %b",
                 i + 1, count_s, tc_s, exp_cnt[i], exp_tc[i]);
      end
    end
    do_reset();
    en = 1; up = 0;
    step();
    checks++;
    if (count_s !== 12'd0 || tc_s !== 1'b1 || ovf_s !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sat_down: got count=%0d tc=%b ovf=%b, want 0 1 1", count_s, tc_s, ovf_s);
    end
    idle_inputs();
  endtask

  task automatic test_load_clamp();
    do_reset();
    load = 1; load_val = 12'd4095; en = 1; up = 1;
    step();
    checks++;
    if (count_k !== 12'd999 || tc_k !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clamp_4095: got count=%0d tc=%b, want 999 0", count_k, tc_k);
    end
    load_val = 12'd1000;
    step();
    checks++;
    if (count_k !== 12'd999 || tc_k !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clamp_1000: got count=%0d tc=%b, want 999 0", count_k, tc_k);
    end
    load_val = 12'd500;
    step();
    checks++;
    if (count_k !== 12'd500) begin
      errors++;
      $display("[TB] FAIL load_500: got count=%0d, want 500", count_k);
    end
    load = 0; en = 0;
    step();
    checks++;
    if (count_k !== 12'd500) begin
      errors++;
      $display("[TB] FAIL hold: got count=%0d, want 500", count_k);
    end
    reset = 1; load = 1; load_val = 12'd321;
    step();
    checks++;
    if (count_k !== 12'd0 || tc_k !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_over_load: got count=%0d tc=%b, want 0 0", count_k, tc_k);
    end
    idle_inputs();
  endtask

  task automatic test_clr_collision();
    do_reset();
    load = 1; load_val = 12'd9;
    step();
    load = 0; en = 1; up = 1; clr_ovf = 1;
    step();
    checks++;
    if (count_m !== 12'd0 || tc_m !== 1'b1 || ovf_m !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clr_collision: got count=%0d tc=%b ovf=%b, want 0 1 1", count_m, tc_m, ovf_m);
    end
    en = 0;
    step();
    checks++;
    if (ovf_m !== 1'b0 || tc_m !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clr_alone: got tc=%b ovf=%b, want 0 0", tc_m, ovf_m);
    end
    idle_inputs();
  endtask

  task automatic test_reset_midcount();
    do_reset();
    load = 1; load_val = 12'd9;
    step();
    load = 0; en = 1; up = 1; reset = 1;
    step();
    checks++;
    if (count_m !== 12'd0 || tc_m !== 1'b0 || ovf_m !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid: got count=%0d tc=%b ovf=%b, want 0 0 0", count_m, tc_m, ovf_m);
    end
    reset = 0;
    step();
    checks++;
    if (count_m !== 12'd1 || tc_m !== 1'b0) begin
      errors++;
      $display("[TB] FAIL resume: got count=%0d tc=%b, want 1 0", count_m, tc_m);
    end
    idle_inputs();
  endtask

  task automatic test_capture();
    logic [11:0] exp_a;
    logic [11:0] exp_b;
`ifdef UPDOWN_MOD_COUNTER_CAPTURE_EN
    exp_a = 12'd37;
    exp_b = 12'd38;
`else
    exp_a = 12'd0;
    exp_b = 12'd0;
`endif
    do_reset();
    load = 1; load_val = 12'd37;
    step();
    load = 0; en = 1; up = 1; capture = 1;
    step();
    checks++;
    if (count_d !== 12'd38 || cap_d !== exp_a) begin
      errors++;
      $display("[TB] FAIL capture_en: got count=%0d cap=%0d, want 38 %0d", count_d, cap_d, exp_a);
    end
    en = 0; load = 1; load_val = 12'd5;
    step();
    checks++;
    if (count_d !== 12'd5 || cap_d !== exp_b) begin
      errors++;
      $display("[TB] FAIL capture_load: got count=%0d cap=%0d, want 5 %0d", count_d, cap_d, exp_b);
    end
    load = 0; capture = 0;
    step();
    checks++;
    if (cap_d !== exp_b) begin
      errors++;
      $display("[TB] FAIL capture_hold: got cap=%0d, want %0d", cap_d, exp_b);
    end
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle_inputs();
    step();
    test_reset();
    test_full_wrap();
    test_down_wrap();
    test_saturate();
    test_load_clamp();
    test_clr_collision();
    test_reset_midcount();
    test_capture();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
